// File: rtl/ped_signal_controller_if.sv
// Signal bundle between the pedestrian sequencer and its environment.
// The master side drives the timing strobe and requests.
// The slave side is the sequencer, which drives the signal head state.
interface ped_signal_controller_if;
  logic       tick;
  logic       enable;
  logic       ped_button;
  logic       cross_green;
  logic [2:0] walk_state;
  logic       ped_pending;
  logic       ped_done;

  modport master (
    output tick, enable, ped_button, cross_green,
    input  walk_state, ped_pending, ped_done
  );

  modport slave (
    input  tick, enable, ped_button, cross_green,
    output walk_state, ped_pending, ped_done
  );
endinterface

// File: rtl/ped_signal_controller.sv
// Pedestrian crossing sequencer.
// A push-button request is latched, then WALK is granted once the traffic
// controller opens the pedestrian phase. After WALK come FLASHING DONT WALK
// and a steady clearance interval, all timed in 1 Hz ticks.
// walk_state is one-hot {walk, flashing_dont_walk, dont_walk}.
module ped_signal_controller #(
  parameter int WALK_TICKS  = 5,
  parameter int FLASH_TICKS = 4,
  parameter int CLEAR_TICKS = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ped_signal_controller_if.slave  ped_if
);

  localparam int MAX_WF = (WALK_TICKS > FLASH_TICKS) ? WALK_TICKS : FLASH_TICKS;
  localparam int MAX_T  = (MAX_WF > CLEAR_TICKS) ? MAX_WF : CLEAR_TICKS;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] CNT_WALK  = CNT_W'(WALK_TICKS);
  localparam logic [CNT_W-1:0] CNT_FLASH = CNT_W'(FLASH_TICKS);
  localparam logic [CNT_W-1:0] CNT_CLEAR = CNT_W'(CLEAR_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_DONTWALK = 3'd1,
    S_WALK     = 3'd2,
    S_FLASH    = 3'd3,
    S_CLEAR    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic [2:0]       walk_q;
  logic             btn_s1_q, btn_s2_q, btn_s3_q;
  logic             press;
  logic             tick_last;

  // Head encoding. CLEAR shows steady DONT WALK, and OFF shows a dark head.
  function automatic logic [2:0] encode_walk(input state_t s);
    case (s)
      S_DONTWALK: encode_walk = 3'b001;
      S_WALK:     encode_walk = 3'b100;
      S_FLASH:    encode_walk = 3'b010;
      S_CLEAR:    encode_walk = 3'b001;
      default:    encode_walk = 3'b000;
    endcase
  endfunction

  // Two-flop synchronizer plus an edge-detect flop for the raw button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_s3_q <= 1'b0;
    end else begin
      btn_s1_q <= ped_if.ped_button;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
    end
  end

  // A held button produces only its rising edge.
  assign press     = btn_s2_q & ~btn_s3_q;
  assign tick_last = ped_if.tick && (cnt_q == CNT_ONE);

  // Next-state, counter, request-latch and done-pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    if (!ped_if.enable) begin
      state_d = S_OFF;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      if (ped_if.tick && (cnt_q != '0)) cnt_d = cnt_q - CNT_ONE;
      // Presses during WALK are already being served, so they are dropped.
      if (press && (state_q != S_WALK)) pend_d = 1'b1;
      case (state_q)
        S_OFF: state_d = S_DONTWALK;
        S_DONTWALK: begin
          if (pend_q && ped_if.cross_green) begin
            state_d = S_WALK;
            cnt_d   = CNT_WALK;
            pend_d  = 1'b0;   // clearing on WALK entry overrides a coincident press
          end
        end
        S_WALK: begin
          // Loss of the phase cuts WALK short but never the flashing interval.
          if (!ped_if.cross_green || tick_last) begin
            state_d = S_FLASH;
            cnt_d   = CNT_FLASH;
          end
        end
        S_FLASH: begin
          if (tick_last) begin
            state_d = S_CLEAR;
            cnt_d   = CNT_CLEAR;
          end
        end
        S_CLEAR: begin
          if (tick_last) begin
            state_d = S_DONTWALK;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_DONTWALK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      walk_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      walk_q  <= encode_walk(state_d);
    end
  end

  assign ped_if.walk_state  = walk_q;
  assign ped_if.ped_pending = pend_q;
  assign ped_if.ped_done    = done_q;

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed bench for ped_signal_controller.
// A phase/elapsed-tick reference model runs alongside the design and is
// compared on every cycle. Literal expectations at key points pin the model.
module tb_ped_signal_controller;
  localparam int WT = 5;
  localparam int FT = 4;
  localparam int CT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ped_signal_controller_if bus();

  ped_signal_controller #(
    .WALK_TICKS (WT),
    .FLASH_TICKS(FT),
    .CLEAR_TICKS(CT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ped_if (bus)
  );

  int errs = 0;
  int checks = 0;

  // Reference model. Phases: 0 off, 1 dont-walk, 2 walk, 3 flash, 4 clear.
  // Ticks elapsed in the current phase are counted upward.
  int       m_phase;
  int       m_elapsed;
  bit       m_pend;
  bit       m_done;
  bit [2:0] m_hist;  // m_hist[0] = most recent sampled button level

  function automatic logic [2:0] phase_code(input int ph);
    case (ph)
      1: return 3'b001;
      2: return 3'b100;
      3: return 3'b010;
      4: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit pr;
    if (!reset_n) begin
      m_phase = 0; m_elapsed = 0; m_pend = 0; m_done = 0; m_hist = 3'b000;
    end else begin
      pr = m_hist[1] && !m_hist[2];
      m_done = 0;
      if (!bus.enable) begin
        m_phase = 0; m_elapsed = 0; m_pend = 0;
      end else begin
        case (m_phase)
          0: begin
            m_phase = 1;
            if (pr) m_pend = 1;
          end
          1: begin
            if (m_pend && bus.cross_green) begin
              m_phase = 2; m_elapsed = 0; m_pend = 0;
            end else if (pr) m_pend = 1;
          end
          2: begin
            if (!bus.cross_green) begin
              m_phase = 3; m_elapsed = 0;
            end else if (bus.tick) begin
              m_elapsed++;
              if (m_elapsed == WT) begin m_phase = 3; m_elapsed = 0; end
            end
          end
          3: begin
            if (pr) m_pend = 1;
            if (bus.tick) begin
              m_elapsed++;
              if (m_elapsed == FT) begin m_phase = 4; m_elapsed = 0; end
            end
          end
          default: begin
            if (pr) m_pend = 1;
            if (bus.tick) begin
              m_elapsed++;
              if (m_elapsed == CT) begin m_phase = 1; m_elapsed = 0; m_done = 1; end
            end
          end
        endcase
      end
      m_hist = {m_hist[1:0], bus.ped_button};
    end
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model_walk_state", bus.walk_state, phase_code(m_phase));
    chk("model_ped_pending", {2'b00, bus.ped_pending}, {2'b00, m_pend});
    chk("model_ped_done", {2'b00, bus.ped_done}, {2'b00, m_done});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic tick1();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
    step();
  endtask

  task automatic press();
    bus.ped_button = 1'b1;
    repeat (4) step();
    bus.ped_button = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.enable = 1'b0;
    bus.ped_button = 1'b0;
    bus.cross_green = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_ws", bus.walk_state, 3'b000);
    chk("rst_pend", {2'b00, bus.ped_pending}, 3'd0);
    chk("rst_done", {2'b00, bus.ped_done}, 3'd0);
    reset_n = 1'b1;
    step();
    chk("off_ws", bus.walk_state, 3'b000);
    bus.enable = 1'b1;
    step();
    chk("en_ws", bus.walk_state, 3'b001);

    // Normal crossing with press latency
    bus.ped_button = 1'b1;
    step(); chk("lat1", {2'b00, bus.ped_pending}, 3'd0);
    step(); chk("lat2", {2'b00, bus.ped_pending}, 3'd0);
    step(); chk("lat3", {2'b00, bus.ped_pending}, 3'd1);
    bus.cross_green = 1'b1;
    step();
    chk("walk_entry", bus.walk_state, 3'b100);
    chk("pend_clr", {2'b00, bus.ped_pending}, 3'd0);
    bus.ped_button = 1'b0;
    repeat (4) tick1();
    chk("walk_4t", bus.walk_state, 3'b100);
    tick1();
    chk("walk_to_flash", bus.walk_state, 3'b010);
    repeat (3) tick1();
    chk("flash_3t", bus.walk_state, 3'b010);
    tick1();
    chk("flash_to_clear", bus.walk_state, 3'b001);
    tick1();
    chk("clear_1t_done", {2'b00, bus.ped_done}, 3'd0);
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
    chk("done_pulse", {2'b00, bus.ped_done}, 3'd1);
    step();
    chk("done_once", {2'b00, bus.ped_done}, 3'd0);

    // Request waits for the phase
    bus.cross_green = 1'b0;
    press();
    repeat (10) tick1();
    chk("wait_ws", bus.walk_state, 3'b001);
    chk("wait_pend", {2'b00, bus.ped_pending}, 3'd1);
    bus.cross_green = 1'b1;
    step();
    chk("green_walk", bus.walk_state, 3'b100);

    // Phase drop mid-WALK still runs full flash and clearance
    repeat (2) tick1();
    bus.cross_green = 1'b0;
    step();
    chk("drop_flash", bus.walk_state, 3'b010);
    repeat (3) tick1();
    chk("drop_flash_3t", bus.walk_state, 3'b010);
    tick1();
    chk("drop_clear", bus.walk_state, 3'b001);
    tick1();
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
    chk("drop_done", {2'b00, bus.ped_done}, 3'd1);

    // Press during FLASH latches and re-enters WALK
    bus.cross_green = 1'b1;
    press();
    chk("t5_walk", bus.walk_state, 3'b100);
    repeat (5) tick1();
    chk("t5_flash", bus.walk_state, 3'b010);
    press();
    chk("flash_press_pend", {2'b00, bus.ped_pending}, 3'd1);
    repeat (4) tick1();
    tick1();
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
    chk("t5_done", {2'b00, bus.ped_done}, 3'd1);
    chk("t5_pend_kept", {2'b00, bus.ped_pending}, 3'd1);
    step();
    chk("rewalk", bus.walk_state, 3'b100);

    // Finish that crossing, then held button and coincident tick
    bus.cross_green = 1'b0;
    step();
    repeat (4) tick1();
    repeat (2) tick1();
    bus.ped_button = 1'b1;
    repeat (20) step();
    bus.ped_button = 1'b0;
    step();
    chk("held_pend", {2'b00, bus.ped_pending}, 3'd1);
    bus.cross_green = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    chk("coinc_walk", bus.walk_state, 3'b100);
    step(); step();
    repeat (4) tick1();
    chk("coinc_walk_4t", bus.walk_state, 3'b100);
    tick1();
    chk("coinc_walk_end", bus.walk_state, 3'b010);
    bus.enable = 1'b0;
    step();
    chk("dis_ws", bus.walk_state, 3'b000);
    chk("dis_pend", {2'b00, bus.ped_pending}, 3'd0);
    repeat (3) tick1();
    chk("dis_no_done", {2'b00, bus.ped_done}, 3'd0);

    // Asynchronous reset with a pending request, then mid-WALK
    bus.enable = 1'b1;
    bus.cross_green = 1'b0;
    step();
    press();
    chk("pre_arst_pend", {2'b00, bus.ped_pending}, 3'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pend", {2'b00, bus.ped_pending}, 3'd0);
    chk("arst_ws_dw", bus.walk_state, 3'b000);
    step();
    reset_n = 1'b1;
    step();
    chk("arst_recover1", bus.walk_state, 3'b001);
    bus.cross_green = 1'b1;
    press();
    tick1();
    chk("pre_arst_walk", bus.walk_state, 3'b100);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_walk_ws", bus.walk_state, 3'b000);
    chk("arst_walk_pend", {2'b00, bus.ped_pending}, 3'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("arst_recover2", bus.walk_state, 3'b001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
